smc_frame_loader: RTL and testbench

//   Serial-to-parallel front end for the Supper MOSFET Calculator (SMC).

---
 rtl/smc_frame_loader.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_smc_frame_loader.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_frame_loader.sv
// smc_frame_loader
// Serial-to-parallel front end for the SMC. It assembles one MOSFET frame
// from 3-bit beats (mode beat, then W / V_GS / V_DS per transistor) and
// presents it on a held parallel bus with a valid/ready handshake.
// There is one assembly buffer and one output buffer, so the next frame can
// stream in while the SMC is still consuming the current one.
module smc_frame_loader #(
    parameter int N_TR = 6,
    parameter int DW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_mode,
    output logic [N_TR*DW-1:0]   out_w,
    output logic [N_TR*DW-1:0]   out_vgs,
    output logic [N_TR*DW-1:0]   out_vds,
    output logic                 out_err,
    output logic [7:0]           out_cnt,
    output logic                 abort,
    output logic                 drop
);

    localparam int FL  = 1 + 3 * N_TR;
    localparam int CW  = $clog2(FL);
    localparam int TRW = (N_TR > 1) ? $clog2(N_TR) : 1;
    localparam int BW  = N_TR * DW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t         state_q, state_d;

    // Beat counter plus the (transistor, field) position the next data beat
    // lands in; keeping the position explicit avoids a divide-by-3.
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TRW-1:0] tr_q, tr_d;
    logic [1:0]     fld_q, fld_d;

    // Assembly buffer
    logic [1:0]     asm_mode_q, asm_mode_d;
    logic [BW-1:0]  asm_w_q, asm_w_d;
    logic [BW-1:0]  asm_vgs_q, asm_vgs_d;
    logic [BW-1:0]  asm_vds_q, asm_vds_d;

    // Output buffer and status registers
    logic           out_valid_q, out_valid_d;
    logic [1:0]     out_mode_q, out_mode_d;
    logic [BW-1:0]  out_w_q, out_w_d;
    logic [BW-1:0]  out_vgs_q, out_vgs_d;
    logic [BW-1:0]  out_vds_q, out_vds_d;
    logic           out_err_q, out_err_d;
    logic [7:0]     out_cnt_q, out_cnt_d;
    logic           abort_q, abort_d;
    logic           drop_q, drop_d;

    // Control strobes decoded from the FSM
    logic           in_ready_s;
    logic           start_s;
    logic           store_s;
    logic           load_s;
    logic           abort_s;
    logic           drop_s;
    logic           last_beat_s;
    logic           out_free_s;
    logic           consume_s;

    // True when any transistor in the frame has a zero width field.
    function automatic logic any_zero_width(input logic [BW-1:0] w);
        logic z;
        z = 1'b0;
        for (int i = 0; i < N_TR; i++) begin
            if (w[DW*i +: DW] == {DW{1'b0}}) begin
                z = 1'b1;
            end else begin
                z = z;
            end
        end
        return z;
    endfunction

    assign consume_s   = out_valid_q & out_ready;
    // OUT can take a new frame if it is empty or is being emptied this edge.
    assign out_free_s  = ~out_valid_q | out_ready;
    assign last_beat_s = (cnt_q == CW'(FL - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_start) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (in_valid && !in_start && last_beat_s) begin
                    state_d = out_free_s ? ST_IDLE : ST_FULL;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_FULL: begin
                if (out_free_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready and the per-beat control strobes
    always_comb begin
        in_ready_s = 1'b1;
        start_s    = 1'b0;
        store_s    = 1'b0;
        load_s     = 1'b0;
        abort_s    = 1'b0;
        drop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_s = in_valid & in_start;
                drop_s  = in_valid & ~in_start;
            end
            ST_COLLECT: begin
                start_s = in_valid & in_start;
                abort_s = in_valid & in_start;
                store_s = in_valid & ~in_start;
                load_s  = in_valid & ~in_start & last_beat_s & out_free_s;
            end
            ST_FULL: begin
                in_ready_s = 1'b0;
                load_s     = out_free_s;
            end
            default: begin
                in_ready_s = 1'b1;
            end
        endcase
    end

    // Assembly buffer and beat position update
    always_comb begin
        cnt_d      = cnt_q;
        tr_d       = tr_q;
        fld_d      = fld_q;
        asm_mode_d = asm_mode_q;
        asm_w_d    = asm_w_q;
        asm_vgs_d  = asm_vgs_q;
        asm_vds_d  = asm_vds_q;
        if (start_s) begin
            asm_mode_d = in_data[1:0];
            cnt_d      = CW'(1);
            tr_d       = {TRW{1'b0}};
            fld_d      = 2'd0;
        end else if (store_s) begin
            for (int i = 0; i < N_TR; i++) begin
                if (tr_q == TRW'(i)) begin
                    case (fld_q)
                        2'd0:    asm_w_d[DW*i +: DW]   = in_data;
                        2'd1:    asm_vgs_d[DW*i +: DW] = in_data;
                        2'd2:    asm_vds_d[DW*i +: DW] = in_data;
                        default: ;
                    endcase
                end else begin
                end
            end
            if (last_beat_s) begin
                cnt_d = {CW{1'b0}};
                tr_d  = {TRW{1'b0}};
                fld_d = 2'd0;
            end else if (fld_q == 2'd2) begin
                cnt_d = cnt_q + CW'(1);
                tr_d  = tr_q + TRW'(1);
                fld_d = 2'd0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                fld_d = fld_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output buffer: load a finished frame, clear on consume, else hold.
    // The load uses the next-state assembly view so the final beat is
    // included when the frame goes straight to OUT.
    always_comb begin
        out_valid_d = out_valid_q;
        out_mode_d  = out_mode_q;
        out_w_d     = out_w_q;
        out_vgs_d   = out_vgs_q;
        out_vds_d   = out_vds_q;
        out_err_d   = out_err_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_mode_d  = asm_mode_d;
            out_w_d     = asm_w_d;
            out_vgs_d   = asm_vgs_d;
            out_vds_d   = asm_vds_d;
            out_err_d   = any_zero_width(asm_w_d);
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (consume_s) begin
            out_cnt_d = out_cnt_q + 8'd1;
        end else begin
            out_cnt_d = out_cnt_q;
        end
        abort_d = abort_s;
        drop_d  = drop_s;
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= {CW{1'b0}};
            tr_q        <= {TRW{1'b0}};
            fld_q       <= 2'd0;
            asm_mode_q  <= 2'd0;
            asm_w_q     <= {BW{1'b0}};
            asm_vgs_q   <= {BW{1'b0}};
            asm_vds_q   <= {BW{1'b0}};
            out_valid_q <= 1'b0;
            out_mode_q  <= 2'd0;
            out_w_q     <= {BW{1'b0}};
            out_vgs_q   <= {BW{1'b0}};
            out_vds_q   <= {BW{1'b0}};
            out_err_q   <= 1'b0;
            out_cnt_q   <= 8'd0;
            abort_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tr_q        <= tr_d;
            fld_q       <= fld_d;
            asm_mode_q  <= asm_mode_d;
            asm_w_q     <= asm_w_d;
            asm_vgs_q   <= asm_vgs_d;
            asm_vds_q   <= asm_vds_d;
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
            out_w_q     <= out_w_d;
            out_vgs_q   <= out_vgs_d;
            out_vds_q   <= out_vds_d;
            out_err_q   <= out_err_d;
            out_cnt_q   <= out_cnt_d;
            abort_q     <= abort_d;
            drop_q      <= drop_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign out_w     = out_w_q;
    assign out_vgs   = out_vgs_q;
    assign out_vds   = out_vds_q;
    assign out_err   = out_err_q;
    assign out_cnt   = out_cnt_q;
    assign abort     = abort_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_smc_frame_loader.sv
// Self-checking bench for smc_frame_loader. A frame-level reference model
// (queue of delivered frames, list of beats of the open frame) predicts all
// outputs each cycle; each test task compares the DUT against it inline.
module tb_smc_frame_loader;

    localparam int N_TR = 6;
    localparam int DW   = 3;
    localparam int FL   = 1 + 3 * N_TR;
    localparam int BW   = N_TR * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_start;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_mode;
    logic [BW-1:0] out_w;
    logic [BW-1:0] out_vgs;
    logic [BW-1:0] out_vds;
    logic          out_err;
    logic [7:0]    out_cnt;
    logic          abort;
    logic          drop;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]    mode;
        logic [BW-1:0] w;
        logic [BW-1:0] vgs;
        logic [BW-1:0] vds;
        logic          err;
    } frame_t;

    typedef struct packed {
        logic          iv;
        logic          is;
        logic [DW-1:0] d;
        logic          ordy;
    } stim_t;

    // Reference model state
    frame_t        outq[$];     // [0] is on OUT, [1] is waiting for OUT
    logic [DW-1:0] beats[$];    // beats of the open frame, mode first
    bit            in_frame;
    logic [7:0]    m_cnt;
    logic          m_abort;
    logic          m_drop;

    stim_t         sq[$];

    smc_frame_loader #(.N_TR(N_TR), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_w     (out_w),
        .out_vgs   (out_vgs),
        .out_vds   (out_vds),
        .out_err   (out_err),
        .out_cnt   (out_cnt),
        .abort     (abort),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        outq.delete();
        beats.delete();
        in_frame = 1'b0;
        m_cnt    = 8'd0;
        m_abort  = 1'b0;
        m_drop   = 1'b0;
    endfunction

    // Beat k (1..FL-1) is field (k-1)%3 of transistor (k-1)/3.
    function automatic frame_t make_frame();
        frame_t        f;
        logic [DW-1:0] b;
        int            t;
        f = '0;
        b = beats[0];
        f.mode = b[1:0];
        for (int k = 1; k < FL; k++) begin
            t = (k - 1) / 3;
            case ((k - 1) % 3)
                0:       f.w[DW*t +: DW]   = beats[k];
                1:       f.vgs[DW*t +: DW] = beats[k];
                default: f.vds[DW*t +: DW] = beats[k];
            endcase
        end
        for (int i = 0; i < N_TR; i++)
            if (f.w[DW*i +: DW] == 3'd0) f.err = 1'b1;
        return f;
    endfunction

    function automatic logic [68:0] exp_vec();
        frame_t f;
        logic   v;
        v = (outq.size() > 0);
        f = '0;
        if (v) f = outq[0];
        return {v, f, m_cnt, m_abort, m_drop, (outq.size() < 2)};
    endfunction

    // Frame data is only meaningful while out_valid is high.
    function automatic logic [68:0] obs_vec();
        logic [56:0] d;
        if (out_valid === 1'b1) d = {out_mode, out_w, out_vgs, out_vds, out_err};
        else d = '0;
        return {out_valid, d, out_cnt, abort, drop, in_ready};
    endfunction

    // One clock: drive inputs, advance the model at the edge, return at negedge.
    task automatic cycle(input stim_t s);
        bit rdy;
        bit cons;
        in_valid  = s.iv;
        in_start  = s.is;
        in_data   = s.d;
        out_ready = s.ordy;
        rdy  = (outq.size() < 2);
        cons = (outq.size() > 0) && s.ordy;
        @(posedge clk);
        m_abort = 1'b0;
        m_drop  = 1'b0;
        if (cons) begin
            void'(outq.pop_front());
            m_cnt = m_cnt + 8'd1;
        end
        if (s.iv && rdy) begin
            if (s.is) begin
                if (in_frame) m_abort = 1'b1;
                beats.delete();
                beats.push_back(s.d);
                in_frame = 1'b1;
            end else if (in_frame) begin
                beats.push_back(s.d);
                if (beats.size() == FL) begin
                    outq.push_back(make_frame());
                    in_frame = 1'b0;
                end
            end else begin
                m_drop = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_start  = 1'b0;
        in_data   = 3'd0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    function automatic void add_frame(input logic [1:0] mode, input logic [BW-1:0] w,
                                      input logic [BW-1:0] vgs, input logic [BW-1:0] vds,
                                      input logic ordy);
        stim_t s;
        s.iv = 1'b1; s.is = 1'b1; s.d = {1'b0, mode}; s.ordy = ordy;
        sq.push_back(s);
        s.is = 1'b0;
        for (int t = 0; t < N_TR; t++) begin
            s.d = w[DW*t +: DW];   sq.push_back(s);
            s.d = vgs[DW*t +: DW]; sq.push_back(s);
            s.d = vds[DW*t +: DW]; sq.push_back(s);
        end
    endfunction

    function automatic void add_idle(input int n, input logic ordy);
        stim_t s;
        s.iv = 1'b0; s.is = 1'b0; s.d = 3'($urandom); s.ordy = ordy;
        for (int i = 0; i < n; i++) sq.push_back(s);
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_start = 1'b1; in_data = 3'd5; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_start = 1'b0; out_ready = 1'b0;
        model_clear();
        total++;
        if ({out_valid, out_mode, out_w, out_vgs, out_vds, out_err, out_cnt, abort, drop} !== 68'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {out_valid, out_mode, out_w, out_vgs, out_vds, out_err, out_cnt, abort, drop});
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        sq.delete();
        add_frame(2'd2, 18'o111111, 18'o222222, 18'o333333, 1'b1);
        add_idle(3, 1'b1);
        foreach (sq[i]) begin
            cycle(sq[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL single cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i == FL - 1) begin
                total++;
                if ({out_valid, out_mode, out_w, out_vgs, out_vds, out_err, out_cnt} !==
                    {1'b1, 2'd2, 18'o111111, 18'o222222, 18'o333333, 1'b0, 8'd0}) begin
                    bad++; $display("FAIL single_latency got v=%b mode=%0d w=%o vgs=%o vds=%o err=%b cnt=%0d",
                                    out_valid, out_mode, out_w, out_vgs, out_vds, out_err, out_cnt);
                end
            end
        end
        total++;
        if (out_cnt !== 8'd1) begin
            bad++; $display("FAIL single_cnt got=%0d want=1", out_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] bw;
        do_reset();
        sq.delete();
        bw = 18'($urandom);
        add_frame(2'($urandom), 18'($urandom), 18'($urandom), 18'($urandom), 1'b0);
        add_frame(2'($urandom), bw, 18'($urandom), 18'($urandom), 1'b0);
        add_idle(4, 1'b0);
        add_idle(4, 1'b1);
        foreach (sq[i]) begin
            cycle(sq[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL backpressure cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i == 2 * FL + 3) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++; $display("FAIL bp_blocked in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
                end
            end
            if (i == 2 * FL + 4) begin
                total++;
                if (out_valid !== 1'b1 || out_w !== bw || in_ready !== 1'b1) begin
                    bad++; $display("FAIL bp_release v=%b w=%o rdy=%b want 1/%o/1", out_valid, out_w, in_ready, bw);
                end
            end
        end
    endtask

    task automatic test_restart();
        stim_t         s;
        logic [BW-1:0] w;
        int            n_abort;
        do_reset();
        sq.delete();
        s.iv = 1'b1; s.is = 1'b1; s.d = 3'd3; s.ordy = 1'b1;
        sq.push_back(s);
        s.is = 1'b0;
        for (int k = 1; k < 7; k++) begin
            s.d = 3'($urandom); sq.push_back(s);
        end
        w = 18'($urandom);
        add_frame(2'd1, w, 18'($urandom), 18'($urandom), 1'b1);
        add_idle(3, 1'b1);
        n_abort = 0;
        foreach (sq[i]) begin
            cycle(sq[i]);
            if (abort === 1'b1) n_abort++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL restart cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i == 7 + FL - 1) begin
                total++;
                if (out_valid !== 1'b1 || out_mode !== 2'd1 || out_w !== w) begin
                    bad++; $display("FAIL restart_frame v=%b mode=%0d w=%o want 1/1/%o", out_valid, out_mode, out_w, w);
                end
            end
        end
        total++;
        if (n_abort !== 1 || out_cnt !== 8'd1) begin
            bad++; $display("FAIL restart_counts aborts=%0d cnt=%0d want 1/1", n_abort, out_cnt);
        end
    endtask

    task automatic test_stray();
        stim_t s;
        int    n_drop;
        int    n_valid;
        do_reset();
        sq.delete();
        s.iv = 1'b1; s.is = 1'b0; s.ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s.d = 3'($urandom); sq.push_back(s);
        end
        add_idle(3, 1'b1);
        n_drop = 0; n_valid = 0;
        foreach (sq[i]) begin
            cycle(sq[i]);
            if (drop === 1'b1) n_drop++;
            if (out_valid !== 1'b0) n_valid++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL stray cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (n_drop !== 3 || n_valid !== 0) begin
            bad++; $display("FAIL stray_counts drops=%0d valids=%0d want 3/0", n_drop, n_valid);
        end
    endtask

    task automatic test_zero_width();
        logic [DW-1:0] w3;
        do_reset();
        sq.delete();
        add_frame(2'd1, 18'o110111, 18'($urandom), 18'($urandom), 1'b0);
        add_idle(3, 1'b0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL zero_width cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        w3 = out_w[9 +: 3];
        total++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || w3 !== 3'd0) begin
            bad++; $display("FAIL zero_width_err v=%b err=%b w3=%0d want 1/1/0", out_valid, out_err, w3);
        end
    endtask

    task automatic test_random();
        stim_t s;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s.iv   = ($urandom_range(0, 3) != 0);
            s.is   = in_frame ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) != 0);
            s.d    = 3'($urandom);
            s.ordy = ($urandom_range(0, 2) != 0);
            cycle(s);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        sq.delete();
        add_frame(2'($urandom), 18'($urandom), 18'($urandom), 18'($urandom), 1'b0);
        add_frame(2'($urandom), 18'($urandom), 18'($urandom), 18'($urandom), 1'b0);
        add_idle(2, 1'b0);
        foreach (sq[i]) begin
            cycle(sq[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_full cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL reset_full_pre in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        rst = 1'b1; in_valid = 1'b1; in_start = 1'b1; in_data = 3'd6; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_start = 1'b0; out_ready = 1'b0;
        model_clear();
        total++;
        if ({out_valid, out_mode, out_w, out_vgs, out_vds, out_err, out_cnt, abort, drop} !== 68'd0
            || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_full_post got=%h rdy=%b want=0 rdy=1",
                            {out_valid, out_mode, out_w, out_vgs, out_vds, out_err, out_cnt, abort, drop}, in_ready);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        sq.delete();
        for (int f = 0; f < 256; f++)
            add_frame(2'($urandom), 18'($urandom), 18'($urandom), 18'($urandom), 1'b1);
        add_idle(3, 1'b1);
        foreach (sq[i]) begin
            cycle(sq[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL wrap cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (out_cnt !== 8'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_cnt cnt=%0d v=%b want 0/0", out_cnt, out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_data = 3'd0; out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_restart();
        test_stray();
        test_zero_width();
        test_random();
        test_reset_full();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
